// File: rtl/alu_divider_seq_pkg.sv
// alu_divider_seq_pkg
// Shared definitions for the sequential divider: operand width, the
// controller state encoding, the quotient reported for a zero divisor, and
// a small magnitude helper used when latching signed operands.
// Ports: none (package only).

package alu_divider_seq_pkg;

  // Operand/result width; the 5-bit step counter assumes exactly 32.
  localparam int WIDTH = 32;

  // Width of the step counter that walks the 32 restoring steps.
  localparam int CNT_W = 5;

  // Quotient reported when the divisor is zero.
  localparam logic [WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFFFFFF;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two's-complement magnitude. 32'h80000000 maps onto itself, which is the
  // correct unsigned magnitude, so the most negative operand needs no special
  // case.
  function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] value);
    return value[WIDTH-1] ? -value : value;
  endfunction

endpackage

// File: rtl/alu_divider_seq_step.sv
// div_step_1bit
// One combinational restoring-division step on the partial remainder and
// the quotient/dividend shift register.
// Ports:
//   i_r        partial remainder before the step
//   i_q        quotient/dividend shift register before the step
//   i_divisor  divisor magnitude
//   o_rNext    partial remainder after the step
//   o_qNext    shift register after the step, new quotient bit in bit 0

module div_step_1bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rNext,
  output logic [WIDTH-1:0] o_qNext
);

  logic [WIDTH:0] w_rShift;
  logic [WIDTH:0] w_trial;
  logic           w_trialNeg;

  // Shift {R,Q} left by one. The shifted remainder can need one extra bit,
  // so the trial subtraction is done one bit wider; since R < divisor always
  // holds, the trial result fits in WIDTH+1 signed bits and its top bit is
  // the sign.
  assign w_rShift   = {i_r, i_q[WIDTH-1]};
  assign w_trial    = w_rShift - {1'b0, i_divisor};
  assign w_trialNeg = w_trial[WIDTH];

  // On a negative trial the old shifted remainder is restored; it is below
  // the divisor in that case so its top bit is zero and may be dropped.
  assign o_rNext = w_trialNeg ? w_rShift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign o_qNext = {i_q[WIDTH-2:0], ~w_trialNeg};

endmodule

// File: rtl/alu_divider_seq.sv
// alu_divider_seq
// Sequential 32-bit restoring divider, signed or unsigned, one quotient bit
// per clock. A request is accepted whenever the block is not busy; results
// appear 33 cycles after the accepting edge (1 cycle for a zero divisor) and
// are held until the next operation completes.
// Ports:
//   clk      clock, rising edge
//   reset    synchronous active-high reset
//   Start    request, ignored while Busy
//   Signed   1 = two's-complement divide, sampled with Start
//   A, B     dividend and divisor, sampled with Start
//   Quot     registered quotient
//   Rem      registered remainder
//   Busy     operation in progress
//   Done     one-cycle completion pulse
//   DivZero  completed operation had a zero divisor

module alu_divider_seq
  import alu_divider_seq_pkg::*;
#(
  parameter int WIDTH = alu_divider_seq_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  state_e             r_state;
  state_e             w_stateNext;
  logic [CNT_W-1:0]   r_count;
  logic               r_lastStep;
  logic               r_zeroOp;
  logic               r_qNeg;
  logic               r_rNeg;
  logic [WIDTH-1:0]   r_partR;
  logic [WIDTH-1:0]   r_partQ;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_aRaw;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic               r_divZero;
  logic [WIDTH-1:0]   w_rNext;
  logic [WIDTH-1:0]   w_qNext;
  logic               w_accept;
  logic [WIDTH-1:0]   w_aMag;
  logic [WIDTH-1:0]   w_bMag;

  div_step_1bit #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_r       (r_partR),
    .i_q       (r_partQ),
    .i_divisor (r_divisor),
    .o_rNext   (w_rNext),
    .o_qNext   (w_qNext)
  );

  // A request is taken in IDLE and also in DONE, which allows back-to-back
  // operations without an idle gap.
  assign w_accept = Start && (r_state != RUN);

  // Magnitudes are only taken in signed mode; unsigned operands pass through.
  assign w_aMag = Signed ? absVal(A) : A;
  assign w_bMag = Signed ? absVal(B) : B;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic. RUN ends either on the cycle after the 32nd step or,
  // for a zero divisor, on the very first RUN cycle without stepping.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_stateNext = RUN;
        end
      end
      RUN: begin
        if (r_zeroOp || r_lastStep) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        w_stateNext = Start ? RUN : IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Datapath. Accepting a request latches magnitudes and sign flags so that
  // later input changes cannot disturb the operation. Each RUN cycle either
  // performs one restoring step or, once the last step is flagged (or the
  // divisor was zero), writes the output registers. The raw dividend is kept
  // separately because a zero divisor reports A exactly as presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_lastStep <= 1'b0;
      r_zeroOp   <= 1'b0;
      r_qNeg     <= 1'b0;
      r_rNeg     <= 1'b0;
      r_partR    <= '0;
      r_partQ    <= '0;
      r_divisor  <= '0;
      r_aRaw     <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_divZero  <= 1'b0;
    end else if (w_accept) begin
      r_count    <= '0;
      r_lastStep <= 1'b0;
      r_zeroOp   <= (B == '0);
      r_qNeg     <= Signed && (A[WIDTH-1] ^ B[WIDTH-1]);
      r_rNeg     <= Signed && A[WIDTH-1];
      r_partR    <= '0;
      r_partQ    <= w_aMag;
      r_divisor  <= w_bMag;
      r_aRaw     <= A;
    end else if (r_state == RUN) begin
      if (r_zeroOp) begin
        r_quot    <= DIV_ZERO_QUOT;
        r_rem     <= r_aRaw;
        r_divZero <= 1'b1;
      end else if (r_lastStep) begin
        r_quot    <= r_qNeg ? -r_partQ : r_partQ;
        r_rem     <= r_rNeg ? -r_partR : r_partR;
        r_divZero <= 1'b0;
      end else begin
        r_partR    <= w_rNext;
        r_partQ    <= w_qNext;
        r_count    <= r_count + 1'b1;
        r_lastStep <= (r_count == {CNT_W{1'b1}});
      end
    end
  end

  assign Quot    = r_quot;
  assign Rem     = r_rem;
  assign DivZero = r_divZero;
  assign Busy    = (r_state == RUN);
  assign Done    = (r_state == DONE);

endmodule

// File: tb/tb_alu_divider_seq.sv
// tb_alu_divider_seq
// Directed bench for alu_divider_seq: each vector carries hand-computed
// quotient, remainder, divide-by-zero flag and latency.

module tb_alu_divider_seq;

  logic        clk;
  logic        reset;
  logic        Start;
  logic        Signed;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Quot;
  logic [31:0] Rem;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  int checks = 0;
  int errors = 0;

  alu_divider_seq #(
    .WIDTH (32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .Signed  (Signed),
    .A       (A),
    .B       (B),
    .Quot    (Quot),
    .Rem     (Rem),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Present one request for exactly one rising edge (edge 0), then scramble
  // the inputs so that any late sampling of them shows up in the results.
  task automatic applyStimulus(input logic s, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clk);
    Start  = 1'b1;
    Signed = s;
    A      = a;
    B      = b;
    @(posedge clk);
    #1;
    Start  = 1'b0;
    Signed = ~s;
    A      = 32'hDEADBEEF;
    B      = 32'h0;
  endtask

  // Count edges after edge 0 until Done, checking Busy along the way. When
  // injectAt matches the current count, a competing 9/3 request is driven
  // for one edge while the divider is busy.
  task automatic waitDone(input string tag, input int injectAt, output int lat);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (lat == injectAt) begin
        Start  = 1'b1;
        Signed = 1'b0;
        A      = 32'd9;
        B      = 32'd3;
      end else begin
        Start  = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (Done) break;
      checkOutput({tag, "_busy"}, {31'b0, Busy}, 32'd1);
    end
    Start = 1'b0;
    if (!Done) begin
      checkOutput({tag, "_doneTimeout"}, {31'b0, Done}, 32'd1);
    end
  endtask

  task automatic checkResult(input string tag, input int lat, input int expLat,
                             input logic [31:0] expQ, input logic [31:0] expR,
                             input logic expZ);
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_quot"}, Quot, expQ);
    checkOutput({tag, "_rem"}, Rem, expR);
    checkOutput({tag, "_divZero"}, {31'b0, DivZero}, {31'b0, expZ});
    checkOutput({tag, "_busyLow"}, {31'b0, Busy}, 32'd0);
  endtask

  // One cycle after a completion with no new request: Done must drop and the
  // results must stay put.
  task automatic checkIdle(input string tag, input logic [31:0] expQ,
                           input logic [31:0] expR, input logic expZ);
    @(posedge clk);
    #1;
    checkOutput({tag, "_donePulse"}, {31'b0, Done}, 32'd0);
    checkOutput({tag, "_quotHeld"}, Quot, expQ);
    checkOutput({tag, "_remHeld"}, Rem, expR);
    checkOutput({tag, "_divZeroHeld"}, {31'b0, DivZero}, {31'b0, expZ});
  endtask

  task automatic runCase(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input int expLat,
                         input logic [31:0] expQ, input logic [31:0] expR,
                         input logic expZ);
    int lat;
    applyStimulus(s, a, b);
    waitDone(tag, -1, lat);
    checkResult(tag, lat, expLat, expQ, expR, expZ);
    checkIdle(tag, expQ, expR, expZ);
  endtask

  // Directed sequence.
  initial begin
    int lat;
    int doneSeen;

    reset  = 1'b1;
    Start  = 1'b1;
    Signed = 1'b0;
    A      = 32'd100;
    B      = 32'd7;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'b0, Busy}, 32'd0);
    checkOutput("reset_done", {31'b0, Done}, 32'd0);
    checkOutput("reset_quot", Quot, 32'd0);
    checkOutput("reset_rem", Rem, 32'd0);
    checkOutput("reset_divZero", {31'b0, DivZero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    Start = 1'b0;

    runCase("u100div7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);
    runCase("sNeg7div2", 1'b1, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    runCase("s7divNeg2", 1'b1, 32'd7, 32'hFFFFFFFE, 33, 32'hFFFFFFFD, 32'd1, 1'b0);
    runCase("uFFF9div2", 1'b0, 32'hFFFFFFF9, 32'd2, 33, 32'h7FFFFFFC, 32'd1, 1'b0);
    runCase("u5div0", 1'b0, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 32'd5, 1'b1);
    runCase("s5div0", 1'b1, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 32'd5, 1'b1);
    runCase("sMinDivNeg1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'd0, 1'b0);
    runCase("uMaxDiv1", 1'b0, 32'hFFFFFFFF, 32'd1, 33, 32'hFFFFFFFF, 32'd0, 1'b0);

    // Request while busy is ignored; a request in the Done cycle starts a new
    // operation immediately.
    applyStimulus(1'b0, 32'd100, 32'd7);
    waitDone("ignoreBusy", 9, lat);
    checkResult("ignoreBusy", lat, 33, 32'd14, 32'd2, 1'b0);
    applyStimulus(1'b0, 32'd9, 32'd3);
    waitDone("backToBack", -1, lat);
    checkResult("backToBack", lat, 33, 32'd3, 32'd0, 1'b0);
    checkIdle("backToBack", 32'd3, 32'd0, 1'b0);

    // Reset at edge 15 of a running operation.
    applyStimulus(1'b0, 32'd100, 32'd7);
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midReset_busy", {31'b0, Busy}, 32'd0);
    checkOutput("midReset_done", {31'b0, Done}, 32'd0);
    checkOutput("midReset_quot", Quot, 32'd0);
    checkOutput("midReset_rem", Rem, 32'd0);
    checkOutput("midReset_divZero", {31'b0, DivZero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    doneSeen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (Done) doneSeen++;
    end
    checkOutput("midReset_noDone", doneSeen, 32'd0);
    runCase("afterReset", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_divider_seq.md
ALU_DIVIDER_SEQ -- requirements
Module: alu_divider_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request; sampled only when not busy.
REQ-005 Signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with Start.
REQ-006 A  input  32  dividend; sampled with Start.
REQ-007 B  input  32  divisor; sampled with Start.
REQ-008 Quot  output  32  quotient, registered.
REQ-009 Rem  output  32  remainder, registered.
REQ-010 Busy  output  1  high while an operation is in progress.
REQ-011 Done  output  1  one-cycle pulse, results valid.
REQ-012 DivZero  output  1  B was zero for the completed operation; held with results.

Function
REQ-013 The block SHALL run three states: IDLE, RUN, DONE.
REQ-014 IDLE/DONE with Start=1 at edge 0 SHALL latch operands, set Busy, clear Done, enter RUN, and load a 5-bit counter with 0.
REQ-015 Signed mode SHALL latch |A| and |B|, and record qneg = A[31]^B[31] and rneg = A[31].
REQ-016 RUN SHALL perform one restoring step per cycle: shift {R,Q} left 1; trial = R - divisor (33-bit); if trial non-negative then R = trial and Q[0] = 1, else Q[0] = 0.
REQ-017 After 32 steps (edges 1..32), the next edge (33) SHALL apply sign fix-up, register Quot/Rem, pulse Done, clear Busy, and enter DONE.
REQ-018 Start-to-Done latency SHALL be exactly 33 cycles for every nonzero divisor.
REQ-019 Fix-up: Quot = qneg ? -Q : Q; Rem = rneg ? -R : R; unsigned mode applies no negation.
REQ-020 B=0 at Start SHALL skip RUN, go to DONE at edge 1 with Done=1, DivZero=1, Quot=32'hFFFFFFFF, Rem=A as presented.
REQ-021 Signed 32'h80000000 / 32'hFFFFFFFF SHALL yield Quot=32'h80000000, Rem=0, DivZero=0, no trap.
REQ-022 Start while Busy=1 SHALL be ignored; operands and progress SHALL be unaffected.
REQ-023 Done SHALL be high for exactly one cycle; Quot, Rem, DivZero SHALL hold until the edge that completes the next operation.
REQ-024 DONE SHALL fall to IDLE after one cycle unless Start=1, in which case a new operation SHALL begin back-to-back.
REQ-025 A, B, Signed changes after the Start edge SHALL have no effect on the operation in progress.

Reset
REQ-026 reset=1 at any edge SHALL force IDLE, Busy=0, Done=0, DivZero=0, Quot=0, Rem=0, counter=0, overriding Start.
REQ-027 reset during RUN SHALL abandon the operation with no Done pulse.

Structure
REQ-028 A shared package SHALL hold WIDTH, the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), and the divide-by-zero quotient constant 32'hFFFFFFFF.
REQ-029 The combinational restoring step SHALL be one sub-module, div_step_1bit, (R, Q, divisor) -> (R_next, Q_next); the FSM, counter, and sign fix-up stay in alu_divider_seq.

Verification
REQ-030 Unsigned 100/7: Start at cycle 0 -> Done at cycle 33, Quot=14, Rem=2, DivZero=0, Busy high cycles 1..33 only.
REQ-031 Signed -7/2 (32'hFFFFFFF9, 2) -> Quot=32'hFFFFFFFD, Rem=32'hFFFFFFFF; signed 7/-2 -> Quot=32'hFFFFFFFD, Rem=1.
REQ-032 A=5, B=0, either mode -> Done at cycle 1, DivZero=1, Quot=32'hFFFFFFFF, Rem=5.
REQ-033 Signed 32'h80000000/32'hFFFFFFFF -> Quot=32'h80000000, Rem=0; unsigned 32'hFFFFFFFF/1 -> Quot=32'hFFFFFFFF, Rem=0.
REQ-034 Start 100/7, then Start 9/3 at cycle 10 -> second request ignored, Done only at cycle 33 with Quot=14; Start 9/3 in the Done cycle -> Quot=3, Rem=0 at cycle 66.
REQ-035 reset at cycle 15 mid-RUN -> no Done, all outputs 0 next cycle, and a following Start 100/7 completes correctly.
